dot_product_seq: RTL and testbench
==================================

Name: dot_product_seq

Overview:
Sequencer that runs one dot-product job on the shared dot_product MAC unit for Gram-Schmidt QR. It accepts a job (column a, column b, length), clears the MAC, and streams rows from the synchronous-read column buffer into the MAC. It asserts the end-of-accumulate strobe, captures the Q8.8 result and returns it over a valid/yumi handshake. It sits between the QR top-level scheduler and one dot_product instance.

Parameters:
N_MAX, 8, maximum vector length (rows per column)
N_COLS, 8, number of columns in the column buffer
ROW_W, $clog2(N_MAX), row index width
COL_W, $clog2(N_COLS), column index width
LEN_W, $clog2(N_MAX+1), job length width

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
v_i  in  1  job request valid
ready_o  out  1  job accept (state eIDLE)
col_a_i  in  COL_W  first operand column
col_b_i  in  COL_W  second operand column
len_i  in  LEN_W  vector length; values above N_MAX are clamped to N_MAX
mem_rd_en_o  out  1  column buffer read enable
mem_row_o  out  ROW_W  row address, shared by both ports
mem_col_a_o  out  COL_W  port A column address
mem_col_b_o  out  COL_W  port B column address
mem_data_a_i  in  16  port A read data, 1 cycle after address
mem_data_b_i  in  16  port B read data, 1 cycle after address
dp_reset_o  out  1  MAC clear (to the MAC's reset_i)
dp_A_o, dp_B_o  out  16 each  MAC operands
dp_A_v_o, dp_B_v_o  out  1 each  MAC start valids
dp_ready_i  in  1  MAC ready
dp_done_acc_o  out  1  last-element strobe
dp_v_i  in  1  MAC result valid
dp_accum_i  in  16  MAC result, Q8.8
dp_yumi_o  out  1  MAC result consume
result_o  out  16  captured dot product, Q8.8
v_o  out  1  result valid
yumi_i  in  1  result consume

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- State enum: eIDLE, eCLEAR, eSTART, eRUN, eWAIT_DP, eDONE.
- Reset values: state eIDLE, k=0, result_r=0. Outputs: ready_o=1, v_o=0, result_o=0, dp_reset_o=1 (see below), all other strobes and valids 0.
- dp_reset_o = reset_i | (state==eCLEAR). A mid-job reset therefore also clears the MAC. Any partial job is dropped and no result is produced.
- eIDLE: on v_i, latch col_a, col_b and the clamped length.
  - len==0: result_r <= 0, go directly to eDONE.
  - Otherwise go to eCLEAR.
- eCLEAR: one cycle with the MAC held in reset. Go to eSTART.
- eSTART: dp_A_v_o=dp_B_v_o=1 with dp_A_o=dp_B_o=0. Issue a read of row 0 (mem_rd_en_o=1, mem_row_o=0).
  - If dp_ready_i, set k=0 and go to eRUN.
  - Otherwise stay, and reissue the row 0 read.
- eRUN (MAC in BUSY, accumulating every cycle):
  - dp_A_o=mem_data_a_i, dp_B_o=mem_data_b_i (row k).
  - If k+1<len, read row k+1.
  - dp_done_acc_o=1 when k==len-1, then go to eWAIT_DP. Otherwise k <= k+1.
- Outside eRUN, dp_A_o/dp_B_o are driven 0. Garbage is never presented during eRUN.
- eWAIT_DP: when dp_v_i, set result_r <= dp_accum_i and dp_yumi_o=1 in the same cycle, then go to eDONE.
- eDONE: v_o=1, result_o=result_r. On yumi_i go to eIDLE. While yumi_i is low, the result is held indefinitely.
- result_o holds its last value outside eDONE.
- Latency: accept at cycle T; eCLEAR at T+1, eSTART at T+2, eRUN T+3..T+2+len, eWAIT_DP T+3+len, v_o at T+4+len (for len≥1, MAC ready). For len==0, v_o at T+1.
- No new job is accepted until the result is consumed (single outstanding job). yumi_i in eDONE returns to eIDLE. ready_o rises the next cycle, not combinationally.
- Arithmetic: none in this block. The Q8.8 format comes from the MAC (accum bits 23:8). Wrap and overflow behaviour belongs to the MAC.

Decomposition:
- Shared package qr_pkg holds:
  - the seq_state_e enum;
  - N_MAX/N_COLS defaults;
  - the Q8.8 constants (Q_FRAC=8, Q_ONE=16'h0100).
- No sub-module: the row counter and FSM are small. dot_product is instantiated alongside in the QR datapath, not inside this block.

Test Plan:
- Basic: col a = [1.0,2.0,3.0,4.0] (0x0100..0x0400), col b = all 0x0100, len=4 -> result_o=0x0A00, v_o at T+8.
- Back-to-back: the same job twice, yumi_i one cycle after v_o -> both results 0x0A00. This proves the MAC is cleared between jobs.
- len boundaries:
  - len=1, a[0]=0x0200, b[0]=0x0180 -> result 0x0300 at T+5.
  - len=0 -> result 0x0000 at T+1, no mem reads, no dp valids.
  - len=9 -> clamped to 8, with 8 reads observed.
- Backpressure: yumi_i held low 20 cycles -> v_o stays 1, result_o stable, ready_o=0, and a v_i pulse is ignored.
- Reset mid-eRUN (k=2): reset_i one cycle -> eIDLE, dp_reset_o=1 that cycle, no v_o. The next job len=4 still returns 0x0A00.
- MAC not ready: hold dp_ready_i=0 for 3 cycles in eSTART -> FSM waits, then completes with the correct result, 3 cycles later than nominal.

Source files
------------

// File: rtl/qr_pkg.sv
// qr_pkg: shared types and constants for the Gram-Schmidt QR datapath.
package qr_pkg;
    localparam int N_MAX_DEF  = 8;
    localparam int N_COLS_DEF = 8;
    localparam int Q_FRAC     = 8;
    localparam logic [15:0] Q_ONE = 16'h0100;
    typedef enum logic [2:0] {
        eIDLE,
        eCLEAR,
        eSTART,
        eRUN,
        eWAIT_DP,
        eDONE
    } seq_state_e;
endpackage

// File: rtl/dot_product_seq.sv
// dot_product_seq: runs one dot-product job on the shared MAC, streaming rows from the column buffer.
module dot_product_seq
    import qr_pkg::*;
#(
    parameter int N_MAX  = N_MAX_DEF,
    parameter int N_COLS = N_COLS_DEF,
    parameter int ROW_W  = $clog2(N_MAX),
    parameter int COL_W  = $clog2(N_COLS),
    parameter int LEN_W  = $clog2(N_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             v_i,
    output logic             ready_o,
    input  logic [COL_W-1:0] col_a_i,
    input  logic [COL_W-1:0] col_b_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             mem_rd_en_o,
    output logic [ROW_W-1:0] mem_row_o,
    output logic [COL_W-1:0] mem_col_a_o,
    output logic [COL_W-1:0] mem_col_b_o,
    input  logic [15:0]      mem_data_a_i,
    input  logic [15:0]      mem_data_b_i,
    output logic             dp_reset_o,
    output logic [15:0]      dp_A_o,
    output logic [15:0]      dp_B_o,
    output logic             dp_A_v_o,
    output logic             dp_B_v_o,
    input  logic             dp_ready_i,
    output logic             dp_done_acc_o,
    input  logic             dp_v_i,
    input  logic [15:0]      dp_accum_i,
    output logic             dp_yumi_o,
    output logic [15:0]      result_o,
    output logic             v_o,
    input  logic             yumi_i
);
    seq_state_e       state_q, state_d;
    logic [ROW_W-1:0] k_q, k_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [COL_W-1:0] col_a_q, col_a_d;
    logic [COL_W-1:0] col_b_q, col_b_d;
    logic [15:0]      result_q, result_d;
    logic [LEN_W-1:0] len_clamp;
    logic             in_run;
    logic             last;
    logic             has_next;

    assign len_clamp = (len_i > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : len_i;
    assign in_run    = state_q == eRUN;
    assign last      = LEN_W'(k_q) == len_q - LEN_W'(1);
    assign has_next  = (LEN_W'(k_q) + LEN_W'(1)) < len_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        len_d    = len_q;
        col_a_d  = col_a_q;
        col_b_d  = col_b_q;
        result_d = result_q;
        case (state_q)
            eIDLE: begin
                if (v_i) begin
                    col_a_d = col_a_i;
                    col_b_d = col_b_i;
                    len_d   = len_clamp;
                    if (len_clamp == '0) begin
                        result_d = '0;
                        state_d  = eDONE;
                    end else begin
                        state_d = eCLEAR;
                    end
                end
            end
            eCLEAR: state_d = eSTART;
            eSTART: begin
                if (dp_ready_i) begin
                    k_d     = '0;
                    state_d = eRUN;
                end
            end
            eRUN: begin
                if (last) state_d = eWAIT_DP;
                else      k_d = k_q + ROW_W'(1);
            end
            eWAIT_DP: begin
                if (dp_v_i) begin
                    result_d = dp_accum_i;
                    state_d  = eDONE;
                end
            end
            eDONE:   state_d = yumi_i ? eIDLE : eDONE;
            default: state_d = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= eIDLE;
            k_q      <= '0;
            len_q    <= '0;
            col_a_q  <= '0;
            col_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            len_q    <= len_d;
            col_a_q  <= col_a_d;
            col_b_q  <= col_b_d;
            result_q <= result_d;
        end
    end

    // eSTART primes row 0; each eRUN cycle consumes row k and prefetches row k+1
    assign ready_o       = state_q == eIDLE;
    assign mem_rd_en_o   = (state_q == eSTART) | (in_run & has_next);
    assign mem_row_o     = in_run ? k_q + ROW_W'(1) : '0;
    assign mem_col_a_o   = col_a_q;
    assign mem_col_b_o   = col_b_q;
    assign dp_reset_o    = reset_i | (state_q == eCLEAR);
    assign dp_A_o        = in_run ? mem_data_a_i : '0;
    assign dp_B_o        = in_run ? mem_data_b_i : '0;
    assign dp_A_v_o      = state_q == eSTART;
    assign dp_B_v_o      = state_q == eSTART;
    assign dp_done_acc_o = in_run & last;
    assign dp_yumi_o     = (state_q == eWAIT_DP) & dp_v_i;
    assign v_o           = state_q == eDONE;
    assign result_o      = result_q;
endmodule

// File: tb/tb_dot_product_seq.sv
// tb_dot_product_seq: directed checks of dot_product_seq against a column buffer and MAC model.
module tb_dot_product_seq;
    import qr_pkg::*;

    logic        clk_i = 0;
    logic        reset_i, v_i, ready_o, yumi_i, v_o;
    logic [2:0]  col_a_i, col_b_i, mem_col_a_o, mem_col_b_o, mem_row_o;
    logic [3:0]  len_i;
    logic        mem_rd_en_o, dp_reset_o, dp_A_v_o, dp_B_v_o, dp_ready_i;
    logic        dp_done_acc_o, dp_v_i, dp_yumi_o;
    logic [15:0] mem_data_a_i, mem_data_b_i, dp_A_o, dp_B_o, dp_accum_i, result_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    dot_product_seq dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .col_a_i(col_a_i), .col_b_i(col_b_i), .len_i(len_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_row_o(mem_row_o),
        .mem_col_a_o(mem_col_a_o), .mem_col_b_o(mem_col_b_o),
        .mem_data_a_i(mem_data_a_i), .mem_data_b_i(mem_data_b_i),
        .dp_reset_o(dp_reset_o), .dp_A_o(dp_A_o), .dp_B_o(dp_B_o),
        .dp_A_v_o(dp_A_v_o), .dp_B_v_o(dp_B_v_o), .dp_ready_i(dp_ready_i),
        .dp_done_acc_o(dp_done_acc_o), .dp_v_i(dp_v_i), .dp_accum_i(dp_accum_i),
        .dp_yumi_o(dp_yumi_o), .result_o(result_o), .v_o(v_o), .yumi_i(yumi_i)
    );

    logic [15:0] mem [8][8];
    always @(posedge clk_i)
        if (mem_rd_en_o) begin
            mem_data_a_i <= mem[mem_col_a_o][mem_row_o];
            mem_data_b_i <= mem[mem_col_b_o][mem_row_o];
        end

    // MAC model: 0 ready, 1 accumulating, 2 result valid; accumulator only clears on its reset
    logic [1:0]         mst;
    logic signed [31:0] acc;
    logic               stall;
    assign dp_ready_i = (mst == 2'd0) && !stall;
    assign dp_v_i     = mst == 2'd2;
    assign dp_accum_i = acc[23:8];
    always @(posedge clk_i)
        if (dp_reset_o) begin
            mst <= 2'd0;
            acc <= 0;
        end else if (mst == 2'd0) begin
            if (dp_A_v_o && dp_B_v_o && dp_ready_i) mst <= 2'd1;
        end else if (mst == 2'd1) begin
            acc <= acc + 32'($signed(dp_A_o) * $signed(dp_B_o));
            if (dp_done_acc_o) mst <= 2'd2;
        end else if (dp_yumi_o) begin
            mst <= 2'd0;
        end

    typedef struct {
        int a, b, l;
        logic [15:0] exp;
        int lat, reads, dpv;
    } vec_t;
    vec_t vecs [8];

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_job(input int a, input int b, input int l, input int sn,
                           output logic [15:0] res, output int lat, output int reads, output int dpv);
        col_a_i = 3'(a);
        col_b_i = 3'(b);
        len_i   = 4'(l);
        v_i     = 1;
        reads   = 0;
        dpv     = 0;
        tick;
        v_i = 0;
        lat = 1;
        while (!v_o && lat < 64) begin
            stall = (lat >= 2) && (lat < 2 + sn);
            #1;
            reads += int'(mem_rd_en_o);
            dpv   += int'(dp_A_v_o | dp_B_v_o);
            tick;
            lat++;
        end
        stall = 0;
        res   = result_o;
    endtask

    task automatic consume(input string nm);
        tick;
        yumi_i = 1;
        check({nm, " ready low in yumi cycle"}, ready_o, 0);
        tick;
        yumi_i = 0;
        check({nm, " ready after yumi"}, {ready_o, v_o}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        int lat, reads, dpv, bad_v, bad_r, bad_rdy, bad_run;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) mem[c][r] = 16'h0000;
        for (int r = 0; r < 8; r++) begin
            mem[0][r] = 16'((r + 1) * 256);
            mem[1][r] = Q_ONE;
            mem[4][r] = 16'hFF00;
        end
        mem[2][0] = 16'h0200;
        mem[3][0] = 16'h0180;
        vecs[0] = '{0, 1, 4, 16'h0A00, 8, 4, 1};
        vecs[1] = '{0, 1, 4, 16'h0A00, 8, 4, 1};
        vecs[2] = '{2, 3, 1, 16'h0300, 5, 1, 1};
        vecs[3] = '{0, 1, 0, 16'h0000, 1, 0, 0};
        vecs[4] = '{0, 1, 9, 16'h2400, 12, 8, 1};
        vecs[5] = '{0, 0, 3, 16'h0E00, 7, 3, 1};
        vecs[6] = '{0, 4, 2, 16'hFD00, 6, 2, 1};
        vecs[7] = '{1, 1, 8, 16'h0800, 12, 8, 1};

        reset_i = 1; v_i = 0; yumi_i = 0; stall = 0;
        col_a_i = 0; col_b_i = 0; len_i = 0;
        tick;
        tick;
        check("reset ready/v_o", {ready_o, v_o}, 2'b10);
        check("reset result", result_o, 0);
        check("reset dp_reset", dp_reset_o, 1);
        check("reset strobes", {mem_rd_en_o, dp_A_v_o, dp_B_v_o, dp_done_acc_o, dp_yumi_o}, 0);
        reset_i = 0;
        #1;
        check("dp_reset released", dp_reset_o, 0);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d ready before job", i), ready_o, 1);
            run_job(vecs[i].a, vecs[i].b, vecs[i].l, 0, res, lat, reads, dpv);
            check($sformatf("v%0d result", i), res, vecs[i].exp);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d reads", i), reads, vecs[i].reads);
            check($sformatf("v%0d dp valid cycles", i), dpv, vecs[i].dpv);
            consume($sformatf("v%0d", i));
        end

        // backpressure: result held, new request ignored
        run_job(0, 1, 4, 0, res, lat, reads, dpv);
        check("bp result", res, 16'h0A00);
        bad_v = 0; bad_r = 0; bad_rdy = 0; bad_run = 0;
        for (int c = 0; c < 20; c++) begin
            v_i = (c == 5);
            col_a_i = 2; col_b_i = 3; len_i = 1;
            tick;
            bad_v   += int'(!v_o);
            bad_r   += int'(result_o !== 16'h0A00);
            bad_rdy += int'(ready_o);
        end
        v_i = 0;
        check("bp v_o held", bad_v, 0);
        check("bp result stable", bad_r, 0);
        check("bp ready low", bad_rdy, 0);
        consume("bp");
        for (int c = 0; c < 10; c++) begin
            tick;
            bad_run += int'(v_o | mem_rd_en_o | dp_A_v_o);
        end
        check("bp ignored request not run", bad_run, 0);

        // reset in eRUN with k=2
        col_a_i = 0; col_b_i = 1; len_i = 4; v_i = 1;
        tick;
        v_i = 0;
        for (int c = 0; c < 4; c++) tick;
        check("mid-run row prefetch k=2", mem_row_o, 3);
        reset_i = 1;
        #1;
        check("mid-run dp_reset", dp_reset_o, 1);
        tick;
        reset_i = 0;
        #1;
        check("after reset idle", {ready_o, dp_reset_o}, 2'b10);
        bad_v = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            bad_v += int'(v_o);
        end
        check("no result after reset", bad_v, 0);
        run_job(0, 1, 4, 0, res, lat, reads, dpv);
        check("post-reset result", res, 16'h0A00);
        check("post-reset latency", lat, 8);
        consume("post-reset");

        // MAC not ready for 3 cycles in eSTART
        run_job(0, 1, 4, 3, res, lat, reads, dpv);
        check("stall result", res, 16'h0A00);
        check("stall latency", lat, 11);
        check("stall reads", reads, 7);
        check("stall dp valid cycles", dpv, 4);
        consume("stall");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
